// File: rtl/instr_loader.sv
// instr_loader: packs host instruction bytes into WR_BYTES-wide words
// Ports: clk/rst_n, start, s_data/s_valid/s_last/s_ready stream in,
//   mem_full/we/wr_data/write_pointer_shift_minusone memory write side,
//   byte_count, done, overflow status.
module instr_loader #(
   parameter int WR_BYTES  = 4,
   parameter int LOG_WR    = 2,
   parameter int MAX_BYTES = 1024,
   parameter int CNT_W     = 11
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [7:0]              s_data,
   input  logic                    s_valid,
   input  logic                    s_last,
   output logic                    s_ready,
   input  logic                    mem_full,
   output logic                    we,
   output logic [8*WR_BYTES-1:0]   wr_data,
   output logic [LOG_WR-1:0]       write_pointer_shift_minusone,
   output logic [CNT_W-1:0]        byte_count,
   output logic                    done,
   output logic                    overflow
);

   typedef enum logic [1:0] {
      IDLE, COLLECT, DONE, ERROR
   } state_t;

   localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_BYTES);
   localparam logic [LOG_WR-1:0] LAST_LANE = LOG_WR'(WR_BYTES-1);

   state_t state, state_nx;

   logic [WR_BYTES-1:0][7:0] pack;
   logic [WR_BYTES-1:0][7:0] word_nx;
   logic [LOG_WR-1:0]        idx;
   logic [CNT_W-1:0]         cnt;
   logic                     last_seen;
   logic                     out_vld;
   logic [8*WR_BYTES-1:0]    out_data;
   logic [LOG_WR-1:0]        out_len;

   logic cnt_full;
   logic accept;
   logic complete;
   logic ovf_hit;
   logic open_ses;

   assign cnt_full = (cnt == MAX_CNT);
   assign accept   = s_valid & s_ready;
   assign complete = accept & ((idx == LAST_LANE) | s_last);
   // A byte offered at capacity is an overflow; bytes after the
   // last one are simply refused.
   assign ovf_hit  = (state == COLLECT) & s_valid & cnt_full
                   & ~last_seen;
   assign open_ses = start & (state != COLLECT);

   // Lanes above idx are already zero because pack clears per word.
   always_comb begin
      word_nx      = pack;
      word_nx[idx] = s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE, ERROR: begin
            if (start) state_nx = COLLECT;
         end
         COLLECT: begin
            if (ovf_hit)              state_nx = ERROR;
            else if (last_seen && we) state_nx = DONE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      // Capacity is folded into ready so a refused byte never
      // looks like a completed handshake to the host.
      s_ready  = (state == COLLECT) & ~last_seen & ~cnt_full
               & (~out_vld | ~mem_full);
      we       = (state == COLLECT) & out_vld & ~mem_full;
      done     = (state == DONE);
      overflow = (state == ERROR);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack      <= '0;
         idx       <= '0;
         cnt       <= '0;
         last_seen <= 1'b0;
         out_vld   <= 1'b0;
         out_data  <= '0;
         out_len   <= '0;
      end else if (open_ses) begin
         pack      <= '0;
         idx       <= '0;
         cnt       <= '0;
         last_seen <= 1'b0;
         out_vld   <= 1'b0;
      end else if (ovf_hit) begin
         out_vld   <= 1'b0;
      end else begin
         if (accept) begin
            cnt <= cnt + 1'b1;
            if (s_last) last_seen <= 1'b1;
            if (complete) begin
               pack     <= '0;
               idx      <= '0;
               out_data <= word_nx;
               out_len  <= idx;
            end else begin
               pack <= word_nx;
               idx  <= idx + 1'b1;
            end
         end
         // Reload wins over drain when both happen on one edge.
         if (complete)  out_vld <= 1'b1;
         else if (we)   out_vld <= 1'b0;
      end
   end

   assign wr_data                      = out_data;
   assign write_pointer_shift_minusone = out_len;
   assign byte_count                   = cnt;

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench for instr_loader
// Directed sessions plus randomized sessions with random mem_full.
module tb_instr_loader;

   localparam int WB = 4;
   localparam int LW = 2;
   localparam int MB = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [7:0]    s_data;
   logic          s_valid;
   logic          s_last;
   logic          s_ready;
   logic          mem_full;
   logic          we;
   logic [31:0]   wr_data;
   logic [LW-1:0] shift;
   logic [CW-1:0] byte_count;
   logic          done;
   logic          overflow;

   instr_loader #(
      .WR_BYTES(WB), .LOG_WR(LW), .MAX_BYTES(MB), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
      .s_ready(s_ready), .mem_full(mem_full), .we(we),
      .wr_data(wr_data),
      .write_pointer_shift_minusone(shift),
      .byte_count(byte_count), .done(done), .overflow(overflow)
   );

   typedef struct {
      logic [31:0] d;
      logic [1:0]  l;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] data_a[16];
   int         checks = 0;
   int         errors = 0;
   bit         mf_rand = 0;

   initial clk = 0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mf_rand) begin
         #1 mem_full = ($urandom_range(0, 2) == 0);
      end
   end

   always @(negedge clk) begin
      if (rst_n && we) begin
         exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_write wr_data=%h shift=%0d required no write",
                     wr_data, shift);
         end else begin
            e = exp_q.pop_front();
            if (wr_data !== e.d || shift !== e.l) begin
               errors++;
               $display("FAIL write_word actual=%h/%0d required=%h/%0d",
                        wr_data, shift, e.d, e.l);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start;
      start = 1;
      tick();
      start = 0;
   endtask

   // Reference: bytes chunked into words of WB, last chunk zero padded.
   task automatic push_words(input int n);
      exp_t e;
      for (int k = 0; k < n; k += WB) begin
         int m;
         m = (n - k > WB) ? WB : n - k;
         e.d = 32'h0;
         for (int j = 0; j < m; j++) e.d[8*j +: 8] = data_a[k+j];
         e.l = 2'(m - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic send(input int n, input bit last, input bit gaps,
                       input bit mid_start);
      for (int i = 0; i < n; i++) begin
         bit ok;
         bit rdy;
         if (gaps && $urandom_range(0, 2) == 0) tick();
         if (mid_start && i == 1) begin
            start = 1;
            tick();
            start = 0;
         end
         s_valid = 1;
         s_data  = data_a[i];
         s_last  = last && (i == n - 1);
         ok = 0;
         for (int c = 0; c < 200 && !ok; c++) begin
            #2 rdy = s_ready;
            @(posedge clk);
            #1 ok = rdy;
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout byte=%0d actual=stalled required=accepted", i);
         end
         s_valid = 0;
         s_last  = 0;
      end
   endtask

   task automatic wait_done(input int n);
      for (int c = 0; c < 300 && !done; c++) @(negedge clk);
      chk("done", 32'(done), 32'd1);
      chk("byte_count", 32'(byte_count), 32'(n));
      chk("overflow_clear", 32'(overflow), 32'd0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 0; start = 0; s_data = 0; s_valid = 0;
      s_last = 0; mem_full = 0;
      #2;
      chk("rst_we", 32'(we), 0);
      chk("rst_ready", 32'(s_ready), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_cnt", 32'(byte_count), 0);
      @(posedge clk);
      #1 rst_n = 1;
      tick();
      chk("idle_ready", 32'(s_ready), 0);

      // eight bytes, two full words, stray start mid-session
      for (int i = 0; i < 8; i++) data_a[i] = 8'(i + 1);
      pulse_start();
      push_words(8);
      send(8, 1, 0, 1);
      wait_done(8);

      // partial word
      data_a[0] = 8'hAA; data_a[1] = 8'hBB; data_a[2] = 8'hCC;
      pulse_start();
      push_words(3);
      send(3, 1, 0, 0);
      wait_done(3);

      // mem_full held for five cycles while streaming
      for (int i = 0; i < 8; i++) data_a[i] = 8'(8'h10 + i);
      pulse_start();
      push_words(8);
      fork
         begin
            tick(); tick();
            mem_full = 1;
            repeat (5) tick();
            mem_full = 0;
         end
      join_none
      send(8, 1, 0, 0);
      wait_done(8);

      // overflow with the last word drained in the same cycle
      for (int i = 0; i < 8; i++) data_a[i] = 8'(8'h40 + i);
      pulse_start();
      push_words(8);
      send(8, 0, 0, 0);
      s_valid = 1; s_data = 8'h99;
      #2 chk("ovf_refuse", 32'(s_ready), 0);
      @(posedge clk);
      #1 s_valid = 0;
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_cnt", 32'(byte_count), 8);
      chk("ovf_ready", 32'(s_ready), 0);
      repeat (3) tick();
      chk("ovf_drained", 32'(exp_q.size()), 0);

      // overflow with a pending word that must be discarded
      for (int i = 0; i < 8; i++) data_a[i] = 8'(8'h60 + i);
      pulse_start();
      chk("ovf_cleared", 32'(overflow), 0);
      push_words(4);
      send(7, 0, 0, 0);
      mem_full = 1;
      data_a[0] = data_a[7];
      send(1, 0, 0, 0);
      s_valid = 1; s_data = 8'h99;
      @(posedge clk);
      #1 s_valid = 0;
      mem_full = 0;
      chk("ovf2_flag", 32'(overflow), 1);
      repeat (5) tick();
      chk("ovf2_we", 32'(we), 0);
      chk("ovf2_queue", 32'(exp_q.size()), 0);

      // single byte session after clearing the error
      data_a[0] = 8'h7F;
      pulse_start();
      chk("ovf2_cleared", 32'(overflow), 0);
      push_words(1);
      send(1, 1, 0, 0);
      wait_done(1);

      // reset in the middle of a session
      data_a[0] = 8'h11; data_a[1] = 8'h22;
      data_a[2] = 8'h33; data_a[3] = 8'h44;
      pulse_start();
      send(3, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_we", 32'(we), 0);
      chk("mid_rst_ready", 32'(s_ready), 0);
      chk("mid_rst_cnt", 32'(byte_count), 0);
      chk("mid_rst_data", wr_data, 0);
      chk("mid_rst_shift", 32'(shift), 0);
      chk("mid_rst_flags", {30'd0, done, overflow}, 0);
      @(posedge clk);
      #1 rst_n = 1;
      tick();
      pulse_start();
      push_words(4);
      send(4, 1, 0, 0);
      wait_done(4);

      // randomized sessions under random back-pressure
      mf_rand = 1;
      for (int s = 0; s < 25; s++) begin
         int n;
         n = $urandom_range(1, MB);
         for (int i = 0; i < n; i++) data_a[i] = 8'($urandom);
         pulse_start();
         push_words(n);
         send(n, 1, 1, 0);
         wait_done(n);
      end
      mf_rand = 0;
      tick();
      mem_full = 0;

      repeat (5) tick();
      chk("final_queue", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
